// File: rtl/pcie_fifo_burst_reader_if.sv
// Bundle of the command, FIFO read-port and TX stream signals around the burst reader.
// master = the reader itself, slave = whoever sits on the other side (FIFO/TX/controller).
interface pcie_fifo_burst_reader_if #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 12
);
   logic              start;
   logic [LEN_W-1:0]  burst_len;
   logic              busy;
   logic              done;
   logic [LEN_W-1:0]  xfer_cnt;
   logic [DATA_W-1:0] fifo_rd_data;
   logic              fifo_rd_vld;
   logic              fifo_rd_en;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              tx_sop;
   logic              tx_eop;

   modport master (
      input  start, burst_len, fifo_rd_data, fifo_rd_vld, tx_ready,
      output busy, done, xfer_cnt, fifo_rd_en, tx_data, tx_valid, tx_sop, tx_eop
   );

   modport slave (
      output start, burst_len, fifo_rd_data, fifo_rd_vld, tx_ready,
      input  busy, done, xfer_cnt, fifo_rd_en, tx_data, tx_valid, tx_sop, tx_eop
   );
endinterface

// File: rtl/pcie_fifo_burst_reader.sv
// Pops burst_len words from the prefetch FIFO and re-emits them as one sop/eop framed
// burst on a registered valid/ready stream, one word per cycle, with backpressure into the FIFO.
module pcie_fifo_burst_reader #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   pcie_fifo_burst_reader_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            state_reg;
   logic [LEN_W-1:0]  rem_reg;
   logic [LEN_W-1:0]  xfer_cnt_reg;
   logic              first_reg;
   logic              busy_reg;
   logic              done_reg;
   logic [DATA_W-1:0] tx_data_reg;
   logic              tx_valid_reg;
   logic              tx_sop_reg;
   logic              tx_eop_reg;

   logic              rd_en;
   logic              pop;
   logic              accept;

   // Pop only when the output register is free or being emptied this cycle.
   assign rd_en  = (state_reg == XFER) && (rem_reg != '0) && (!tx_valid_reg || bus.tx_ready);
   assign pop    = rd_en && bus.fifo_rd_vld;
   assign accept = tx_valid_reg && bus.tx_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         rem_reg      <= '0;
         xfer_cnt_reg <= '0;
         first_reg    <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         tx_data_reg  <= '0;
         tx_valid_reg <= 1'b0;
         tx_sop_reg   <= 1'b0;
         tx_eop_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;

         if (accept) begin
            xfer_cnt_reg <= xfer_cnt_reg + LEN_W'(1);
         end

         // A pop always refills the register, so accept+pop keeps tx_valid high.
         if (pop) begin
            tx_data_reg  <= bus.fifo_rd_data;
            tx_valid_reg <= 1'b1;
            tx_sop_reg   <= first_reg;
            tx_eop_reg   <= (rem_reg == LEN_W'(1));
         end else if (accept) begin
            tx_valid_reg <= 1'b0;
            tx_sop_reg   <= 1'b0;
            tx_eop_reg   <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  if (bus.burst_len != '0) begin
                     rem_reg      <= bus.burst_len;
                     xfer_cnt_reg <= '0;
                     first_reg    <= 1'b1;
                     busy_reg     <= 1'b1;
                     state_reg    <= XFER;
                  end else begin
                     xfer_cnt_reg <= '0;
                     done_reg     <= 1'b1;
                  end
               end
            end
            XFER: begin
               if (pop) begin
                  rem_reg   <= rem_reg - LEN_W'(1);
                  first_reg <= 1'b0;
                  if (rem_reg == LEN_W'(1)) begin
                     state_reg <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (accept && tx_eop_reg) begin
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.busy       = busy_reg;
   assign bus.done       = done_reg;
   assign bus.xfer_cnt   = xfer_cnt_reg;
   assign bus.tx_data    = tx_data_reg;
   assign bus.tx_valid   = tx_valid_reg;
   assign bus.tx_sop     = tx_sop_reg;
   assign bus.tx_eop     = tx_eop_reg;

endmodule
